// File: rtl/frame_buf_arb_if.sv
// Bus bundle for frame_buf_arb: writer port, reader port, memory port and owner status.
// The arbiter connects through the slave modport; the environment uses master.
interface frame_buf_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 29
);
    // Writer port
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr_in;
    logic [DATA_WIDTH-1:0] wr_data_in;
    logic                  wr_ack;

    // Reader port
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr_in;
    logic                  rd_ack;
    logic [DATA_WIDTH-1:0] rd_data_out;
    logic                  rd_err;

    // Memory port (strobes active-low)
    logic                  mem_wr_en_l;
    logic                  mem_rd_en_l;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_wr_rdy;
    logic                  mem_rd_data_valid;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Current arbiter state
    logic [1:0]            owner;

    modport slave (
        input  wr_req, wr_addr_in, wr_data_in,
        input  rd_req, rd_addr_in,
        input  mem_wr_rdy, mem_rd_data_valid, mem_rd_data,
        output wr_ack, rd_ack, rd_data_out, rd_err,
        output mem_wr_en_l, mem_rd_en_l, mem_wr_addr, mem_rd_addr, mem_wr_data,
        output owner
    );

    modport master (
        output wr_req, wr_addr_in, wr_data_in,
        output rd_req, rd_addr_in,
        output mem_wr_rdy, mem_rd_data_valid, mem_rd_data,
        input  wr_ack, rd_ack, rd_data_out, rd_err,
        input  mem_wr_en_l, mem_rd_en_l, mem_wr_addr, mem_rd_addr, mem_wr_data,
        input  owner
    );
endinterface

// File: rtl/frame_buf_arb.sv
// Two-port (writer/reader) arbiter in front of a single-ported frame memory.
// Writes stream one word per cycle while granted; reads are strobe-then-wait with
// a timeout. Bursts are capped at BURST_LEN words when the other port is waiting.
module frame_buf_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 29,
    parameter int BURST_LEN  = 16,
    parameter int RD_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    frame_buf_arb_if.slave    bus
);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(RD_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WRITE   = 2'd1;
    localparam logic [1:0] S_READ    = 2'd2;
    localparam logic [1:0] S_RD_WAIT = 2'd3;

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    logic [1:0]            state_q, state_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  last_grant_q, last_grant_d;
    logic                  rd_drop_q, rd_drop_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  rd_err_q, rd_err_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  wr_accept;
    logic                  rd_live;
    logic [BW-1:0]         burst_inc;

    // A word is taken whenever the write strobe is low, the writer still wants it
    // and the memory is ready.
    assign wr_accept = (state_q == S_WRITE) && bus.wr_req && bus.mem_wr_rdy;

    // The reader is still waiting on this transaction (never dropped rd_req).
    assign rd_live   = !rd_drop_q && bus.rd_req;

    // Burst count saturates at BURST_LEN so it can never wrap.
    assign burst_inc = (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);

    // Memory strobes decode straight from the state, so at most one is ever low.
    assign bus.mem_wr_en_l = (state_q != S_WRITE);
    assign bus.mem_rd_en_l = (state_q != S_READ);
    assign bus.mem_wr_addr = (state_q == S_WRITE) ? bus.wr_addr_in : '0;
    assign bus.mem_wr_data = (state_q == S_WRITE) ? bus.wr_data_in : '0;
    assign bus.mem_rd_addr = (state_q == S_READ)  ? bus.rd_addr_in : '0;

    assign bus.wr_ack      = wr_accept;
    assign bus.rd_ack      = rd_ack_q;
    assign bus.rd_err      = rd_err_q;
    assign bus.rd_data_out = rd_data_q;
    assign bus.owner       = state_q;

    // Next-state and datapath decisions for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        tmo_d        = tmo_q;
        last_grant_d = last_grant_q;
        rd_drop_d    = rd_drop_q;
        rd_ack_d     = 1'b0;
        rd_err_d     = 1'b0;
        rd_data_d    = rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (rd_ack_q) begin
                    // Cycle in which rd_ack is presented: the read burst may carry
                    // on (count kept) if the reader immediately re-requests, unless
                    // the writer is waiting and the read burst is used up.
                    if (bus.rd_req && (!bus.wr_req || burst_q != BURST_MAX)) begin
                        state_d = S_READ;
                    end else if (bus.wr_req && burst_q == BURST_MAX) begin
                        state_d = S_WRITE;
                        burst_d = '0;
                    end
                end else if (bus.wr_req && (!bus.rd_req || last_grant_q == GRANT_RD)) begin
                    state_d = S_WRITE;
                    burst_d = '0;
                end else if (bus.rd_req) begin
                    state_d = S_READ;
                    burst_d = '0;
                end
            end

            S_WRITE: begin
                last_grant_d = GRANT_WR;
                if (!bus.wr_req) begin
                    state_d = S_IDLE;
                end else if (wr_accept) begin
                    burst_d = burst_inc;
                    if (burst_inc == BURST_MAX && bus.rd_req) begin
                        state_d = S_READ;
                        burst_d = '0;
                    end
                end
            end

            S_READ: begin
                // One-cycle strobe, then wait for data with a fresh timeout.
                last_grant_d = GRANT_RD;
                tmo_d        = '0;
                rd_drop_d    = !bus.rd_req;
                state_d      = S_RD_WAIT;
            end

            default: begin // S_RD_WAIT
                rd_drop_d = rd_drop_q | !bus.rd_req;
                if (bus.mem_rd_data_valid) begin
                    state_d = S_IDLE;
                    if (rd_live) begin
                        rd_data_d = bus.mem_rd_data;
                        rd_ack_d  = 1'b1;
                        burst_d   = burst_inc;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d      = S_IDLE;
                    rd_err_d     = rd_live;
                    last_grant_d = GRANT_RD;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            burst_q      <= '0;
            tmo_q        <= '0;
            last_grant_q <= GRANT_RD;
            rd_drop_q    <= 1'b0;
            rd_ack_q     <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            tmo_q        <= tmo_d;
            last_grant_q <= last_grant_d;
            rd_drop_q    <= rd_drop_d;
            rd_ack_q     <= rd_ack_d;
            rd_err_q     <= rd_err_d;
            rd_data_q    <= rd_data_d;
        end
    end
endmodule

// File: tb/tb_frame_buf_arb.sv
// Directed self-checking bench for frame_buf_arb (BURST_LEN=4, RD_TIMEOUT=8).
module tb_frame_buf_arb;
    localparam int DW = 32;
    localparam int AW = 29;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    frame_buf_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    frame_buf_arb #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BURST_LEN (4),
        .RD_TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int wr_ack_cnt = 0, rd_ack_cnt = 0, rd_err_cnt = 0, rd_strobe_cnt = 0, both_low_cnt = 0;

    // Transaction monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (!bus.mem_wr_en_l && !bus.mem_rd_en_l) both_low_cnt <= both_low_cnt + 1;
            if (!bus.mem_rd_en_l) rd_strobe_cnt <= rd_strobe_cnt + 1;
            if (bus.wr_ack) begin
                wr_ack_cnt <= wr_ack_cnt + 1;
                $display("[%0t] write ack addr=%0h data=%0h", $time, bus.mem_wr_addr, bus.mem_wr_data);
            end
            if (bus.rd_ack) begin
                rd_ack_cnt <= rd_ack_cnt + 1;
                $display("[%0t] read ack data=%0h", $time, bus.rd_data_out);
            end
            if (bus.rd_err) begin
                rd_err_cnt <= rd_err_cnt + 1;
                $display("[%0t] read timeout", $time);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one write word and wait (bounded) for it to be accepted.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        bus.wr_req     = 1'b1;
        bus.wr_addr_in = a;
        bus.wr_data_in = d;
        #1;
        n = 0;
        while (!bus.wr_ack && n < 20) begin
            cyc();
            #1;
            n++;
        end
        chk("wr_ack_seen", bus.wr_ack, 1);
        chk("mem_wr_addr", bus.mem_wr_addr, a);
        chk("mem_wr_data", bus.mem_wr_data, d);
        chk("rd_strobe_during_write", bus.mem_rd_en_l, 1);
        cyc();
    endtask

    string ev;
    string ev_exp;
    logic [AW-1:0] waddr;
    logic prev_rd_strobe;
    logic adv;

    initial begin
        reset                 = 1'b1;
        bus.wr_req            = 1'b0;
        bus.wr_addr_in        = '0;
        bus.wr_data_in        = '0;
        bus.rd_req            = 1'b0;
        bus.rd_addr_in        = '0;
        bus.mem_wr_rdy        = 1'b0;
        bus.mem_rd_data_valid = 1'b0;
        bus.mem_rd_data       = '0;

        // Reset state
        cyc(); cyc();
        chk("rst_owner", bus.owner, 0);
        chk("rst_wr_en_l", bus.mem_wr_en_l, 1);
        chk("rst_rd_en_l", bus.mem_rd_en_l, 1);
        chk("rst_wr_ack", bus.wr_ack, 0);
        chk("rst_rd_ack", bus.rd_ack, 0);
        chk("rst_rd_err", bus.rd_err, 0);
        chk("rst_rd_data", bus.rd_data_out, 0);
        chk("rst_mem_wr_addr", bus.mem_wr_addr, 0);
        chk("rst_mem_rd_addr", bus.mem_rd_addr, 0);
        chk("rst_mem_wr_data", bus.mem_wr_data, 0);
        reset = 1'b0;
        cyc();

        // Four writes 0x10..0x13 / 0xA0..0xA3
        bus.mem_wr_rdy = 1'b1;
        for (int i = 0; i < 4; i++) do_write(AW'(32'h10 + i), 32'hA0 + i);
        bus.wr_req = 1'b0;
        #1;
        chk("wr_drop_owner", bus.owner, 1);
        chk("wr_drop_no_ack", bus.wr_ack, 0);
        cyc();
        chk("wr_end_owner", bus.owner, 0);
        chk("wr_end_strobe", bus.mem_wr_en_l, 1);
        chk("wr_ack_count", wr_ack_cnt, 4);
        chk("no_rd_strobe_in_writes", rd_strobe_cnt, 0);

        // Read 0x10, data two cycles after strobe; owner 2,3,3,0
        bus.rd_req     = 1'b1;
        bus.rd_addr_in = AW'(32'h10);
        cyc();
        chk("rd_owner0", bus.owner, 2);
        chk("rd_strobe", bus.mem_rd_en_l, 0);
        chk("rd_addr", bus.mem_rd_addr, 32'h10);
        cyc();
        chk("rd_owner1", bus.owner, 3);
        chk("rd_wait_strobe", bus.mem_rd_en_l, 1);
        cyc();
        chk("rd_owner2", bus.owner, 3);
        bus.mem_rd_data_valid = 1'b1;
        bus.mem_rd_data       = 32'hA0;
        cyc();
        bus.mem_rd_data_valid = 1'b0;
        bus.mem_rd_data       = '0;
        chk("rd_owner3", bus.owner, 0);
        chk("rd_ack_pulse", bus.rd_ack, 1);
        chk("rd_data", bus.rd_data_out, 32'hA0);
        bus.rd_req = 1'b0;
        cyc();
        chk("rd_ack_cleared", bus.rd_ack, 0);
        chk("rd_ack_count", rd_ack_cnt, 1);

        // Stray valid in IDLE is ignored
        bus.mem_rd_data_valid = 1'b1;
        bus.mem_rd_data       = 32'h55;
        cyc();
        bus.mem_rd_data_valid = 1'b0;
        chk("stray_no_ack", bus.rd_ack, 0);
        chk("stray_data_kept", bus.rd_data_out, 32'hA0);
        chk("stray_owner", bus.owner, 0);

        // Reader abandons during RD_WAIT: data arrives, no ack
        bus.rd_req     = 1'b1;
        bus.rd_addr_in = AW'(32'h40);
        cyc(); cyc();
        chk("abandon_wait_owner", bus.owner, 3);
        bus.rd_req            = 1'b0;
        bus.mem_rd_data_valid = 1'b1;
        bus.mem_rd_data       = 32'h99;
        cyc();
        bus.mem_rd_data_valid = 1'b0;
        chk("abandon_no_ack", bus.rd_ack, 0);
        chk("abandon_data_kept", bus.rd_data_out, 32'hA0);
        chk("abandon_owner", bus.owner, 0);

        // Read timeout: rd_err exactly 8 cycles after RD_WAIT entry
        bus.rd_req     = 1'b1;
        bus.rd_addr_in = AW'(32'h20);
        cyc();
        chk("tmo_read_owner", bus.owner, 2);
        cyc();
        chk("tmo_wait_entry_owner", bus.owner, 3);
        for (int k = 1; k < 8; k++) cyc();
        chk("tmo_last_wait_owner", bus.owner, 3);
        chk("tmo_no_err_early", bus.rd_err, 0);
        cyc();
        chk("tmo_err_pulse", bus.rd_err, 1);
        chk("tmo_owner_idle", bus.owner, 0);
        chk("tmo_no_ack", bus.rd_ack, 0);
        bus.rd_req = 1'b0;
        cyc();
        chk("tmo_err_cleared", bus.rd_err, 0);
        chk("tmo_err_count", rd_err_cnt, 1);

        // Reset during RD_WAIT, valid arriving afterwards
        bus.rd_req     = 1'b1;
        bus.rd_addr_in = AW'(32'h30);
        cyc(); cyc();
        chk("rstmid_owner", bus.owner, 3);
        reset = 1'b1;
        cyc();
        chk("rstmid_owner_idle", bus.owner, 0);
        chk("rstmid_rd_strobe", bus.mem_rd_en_l, 1);
        chk("rstmid_wr_strobe", bus.mem_wr_en_l, 1);
        reset                 = 1'b0;
        bus.rd_req            = 1'b0;
        bus.mem_rd_data_valid = 1'b1;
        bus.mem_rd_data       = 32'h77;
        cyc();
        bus.mem_rd_data_valid = 1'b0;
        chk("rstmid_no_ack", bus.rd_ack, 0);
        chk("rstmid_rd_data", bus.rd_data_out, 0);
        chk("rstmid_rd_err", bus.rd_err, 0);
        chk("rstmid_mem_rd_addr", bus.mem_rd_addr, 0);
        chk("rstmid_ack_count", rd_ack_cnt, 1);
        cyc();

        // Both ports busy with BURST_LEN=4: writer wins first, 4 writes then 1 read
        ev             = "";
        ev_exp         = "WWWWRWWWWRWWWWR";
        waddr          = AW'(32'h100);
        prev_rd_strobe = 1'b0;
        adv            = 1'b0;
        for (int n = 0; n < 300 && ev.len() < 15; n++) begin
            if (adv) waddr = waddr + AW'(1);
            adv                   = 1'b0;
            bus.wr_req            = 1'b1;
            bus.wr_addr_in        = waddr;
            bus.wr_data_in        = 32'hC000_0000 | 32'(waddr);
            bus.rd_req            = !bus.rd_ack;
            bus.rd_addr_in        = AW'(32'h200);
            bus.mem_rd_data_valid = prev_rd_strobe;
            bus.mem_rd_data       = 32'hB000 + n;
            #1;
            if (bus.rd_ack) ev = {ev, "R"};
            if (bus.wr_ack) begin
                ev  = {ev, "W"};
                adv = 1'b1;
            end
            prev_rd_strobe = !bus.mem_rd_en_l;
            if (ev.len() < 15) cyc();
        end
        checks++;
        assert (ev == ev_exp) else begin
            errors++;
            $error("FAIL grant_sequence observed=%s expected=%s", ev, ev_exp);
        end
        bus.wr_req            = 1'b0;
        bus.rd_req            = 1'b0;
        bus.mem_rd_data_valid = 1'b0;
        cyc();
        cyc();
        chk("mixed_end_owner", bus.owner, 0);
        chk("never_both_strobes_low", both_low_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/frame_buf_arb.md
FRAME_BUF_ARB -- requirements
Module: frame_buf_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width.
REQ-002 Parameter ADDR_WIDTH, default 29, memory address width.
REQ-003 Parameter BURST_LEN, default 16, max consecutive words granted to one port while the other port requests.
REQ-004 Parameter RD_TIMEOUT, default 8, max cycles waited for read data.
REQ-005 clk  in  1  sole clock; all state changes on posedge clk.
REQ-006 reset  in  1  synchronous, active-high; sampled only on posedge clk.
REQ-007 wr_req  in  1  writer has a word pending; held with wr_addr_in/wr_data_in stable until wr_ack.
REQ-008 wr_addr_in  in  ADDR_WIDTH  write address.
REQ-009 wr_data_in  in  DATA_WIDTH  write data.
REQ-010 wr_ack  out  1  one-cycle pulse: word accepted by memory.
REQ-011 rd_req  in  1  reader has a read pending; held with rd_addr_in stable until rd_ack or rd_err.
REQ-012 rd_addr_in  in  ADDR_WIDTH  read address.
REQ-013 rd_ack  out  1  one-cycle pulse: rd_data_out valid.
REQ-014 rd_data_out  out  DATA_WIDTH  read data, held until next rd_ack.
REQ-015 rd_err  out  1  one-cycle pulse: read timed out.
REQ-016 mem_wr_en_l, mem_rd_en_l  out  1 each  memory strobes, active-low.
REQ-017 mem_wr_addr, mem_rd_addr  out  ADDR_WIDTH  memory addresses.
REQ-018 mem_wr_data  out  DATA_WIDTH  memory write data.
REQ-019 mem_wr_rdy, mem_rd_data_valid  in  1 each  memory status, active-high.
REQ-020 mem_rd_data  in  DATA_WIDTH  memory read data.
REQ-021 owner  out  2  current state encoding: 0 IDLE, 1 WRITE, 2 READ, 3 RD_WAIT.

Function
REQ-022 The block SHALL implement FSM states IDLE, WRITE, READ, RD_WAIT; mem_wr_en_l and mem_rd_en_l SHALL never both be low in the same cycle.
REQ-023 IDLE: both strobes high; wr_req only -> WRITE; rd_req only -> READ; both -> port not served last (last_grant register, reset value = read, so writer wins first tie).
REQ-024 WRITE: mem_wr_en_l=0, mem_wr_addr/mem_wr_data driven from wr_addr_in/wr_data_in combinationally; a word is accepted in any cycle with mem_wr_en_l=0, wr_req=1 and mem_wr_rdy=1 -> wr_ack=1 same cycle, burst counter +1.
REQ-025 WRITE exit: wr_req=0 -> IDLE (strobe high next cycle); burst counter = BURST_LEN on acceptance and rd_req=1 -> READ; otherwise stay.
REQ-026 READ: mem_rd_en_l=0 for exactly one cycle with mem_rd_addr=rd_addr_in, then -> RD_WAIT; timeout counter cleared.
REQ-027 RD_WAIT: mem_rd_en_l=1; on mem_rd_data_valid=1 register mem_rd_data into rd_data_out, rd_ack=1 next cycle, burst counter +1.
REQ-028 RD_WAIT exit after data: rd_req still high next cycle and (wr_req=0 or burst counter < BURST_LEN) -> READ; wr_req=1 with burst exhausted -> WRITE; else IDLE.
REQ-029 RD_WAIT timeout: RD_TIMEOUT cycles without mem_rd_data_valid -> rd_err pulse, -> IDLE, last_grant = read.
REQ-030 Burst counter SHALL be 0..BURST_LEN, cleared on every port switch and on entry from IDLE; it SHALL never wrap.
REQ-031 mem_rd_data_valid outside RD_WAIT SHALL be ignored (no rd_ack).
REQ-032 Requester dropping req before ack: transaction abandoned, no ack, FSM returns to IDLE (RD_WAIT still completes or times out, rd_ack suppressed).
REQ-033 Read latency: rd_req in IDLE -> mem_rd_en_l low next cycle -> rd_ack one cycle after mem_rd_data_valid.

Reset
REQ-034 reset=1 at posedge SHALL force: state IDLE, both strobes high, wr_ack/rd_ack/rd_err 0, rd_data_out 0, mem addresses/data 0, counters 0, last_grant = read, owner 0.
REQ-035 Reset mid-transaction SHALL abort it without ack; strobes high in the first cycle after reset.

Verification
REQ-036 wr_req with addr 0x10..0x13, data 0xA0..0xA3, mem_wr_rdy=1 -> 4 wr_ack pulses, mem_rd_en_l stays high.
REQ-037 rd_req addr 0x10, memory returns 0xA0 2 cycles after strobe -> rd_data_out=0xA0, single rd_ack, owner sequence 2,3,3,0.
REQ-038 wr_req and rd_req both high from IDLE, BURST_LEN=4 -> 4 writes, then one read, alternation thereafter; never both strobes low.
REQ-039 rd_req with mem_rd_data_valid never asserted -> rd_err exactly RD_TIMEOUT cycles after RD_WAIT entry, state IDLE.
REQ-040 reset asserted during RD_WAIT, valid arriving after -> no rd_ack, all outputs at reset values.
REQ-041 Stray mem_rd_data_valid in IDLE -> no rd_ack, rd_data_out unchanged.
